// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a circular FIFO: pops storage into a single output
// register with valid/ready handshake, reports occupancy and a sticky error.
module fifo_rd_ctrl #(
  parameter int MAX_DATA = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] wptr,
  input  logic       wwrap,
  input  logic [7:0] rdata,
  output logic [3:0] raddr,
  output logic       ren,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       empty,
  output logic [4:0] level,
  output logic       err
);

  localparam logic [4:0] DEPTH    = 5'(MAX_DATA);
  localparam logic [3:0] LAST_PTR = 4'(MAX_DATA - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] rptr_q, rptr_d;
  logic       rwrap_q, rwrap_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;

  logic [4:0] occupancy;
  logic       load;

  always_comb begin
    empty = (wptr == rptr_q) && (wwrap == rwrap_q);
    // Differing wrap bits mean the writer has lapped the reader once.
    if (wwrap == rwrap_q) begin
      occupancy = {1'b0, wptr} - {1'b0, rptr_q};
    end else begin
      occupancy = DEPTH - {1'b0, rptr_q} + {1'b0, wptr};
    end
    level = occupancy + {4'd0, out_valid_q};
    load  = !empty && (!out_valid_q || out_ready);
  end

  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    rwrap_d    = rwrap_q;
    out_data_d = out_data_q;
    err_d      = err_q;

    if (load) begin
      out_data_d = rdata;
      if (rptr_q == LAST_PTR) begin
        rptr_d  = 4'd0;
        rwrap_d = !rwrap_q;
      end else begin
        rptr_d = rptr_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!load && out_ready && empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == HOLD);

    if (({1'b0, wptr} >= DEPTH) || (occupancy > DEPTH)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rptr_q      <= 4'd0;
      rwrap_q     <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      rwrap_q     <= rwrap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign raddr     = rptr_q;
  assign ren       = load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule
